// File: rtl/event_stretcher_if.sv
// Event-in / stretched-pulse-out bundle for event_stretcher.
// The master side drives events; the slave side (the stretcher) returns the pulse and queue status.
interface event_stretcher_if #(
  parameter int PEND_WIDTH = 3
);
  logic                  in;
  logic                  out;
  logic                  busy;
  logic [PEND_WIDTH-1:0] pending;
  logic                  overflow;

  modport master (
    output in,
    input  out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  in,
    output out,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/event_stretcher.sv
// Turns each rising edge of a clean event input into a fixed-length visible pulse plus a gap.
// Edges that arrive while a pulse is running are queued in a saturating counter.
module event_stretcher #(
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 4,
  parameter int PEND_WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  event_stretcher_if.slave bus
);

  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]         ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]         OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t                state_reg, state_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic [PEND_WIDTH-1:0] pending_reg, pending_next;
  logic                  in_prev_reg;
  logic                  out_reg;
  logic                  busy_reg;
  logic                  overflow_reg, overflow_next;
  logic                  rise;
  logic                  start;

  assign rise = bus.in & ~in_prev_reg;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg != '0) begin
          state_next = ON;
          timer_next = ON_LOAD;
          start      = 1'b1;
        end
      end
      ON: begin
        if (timer_reg == '0) begin
          state_next = OFF;
          timer_next = OFF_LOAD;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      OFF: begin
        if (timer_reg == '0) begin
          // Queued events chain straight into the next pulse without passing through IDLE.
          if (pending_reg != '0) begin
            state_next = ON;
            timer_next = ON_LOAD;
            start      = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A rise on the same edge a pulse starts cancels out, so a full queue never overflows then.
  always_comb begin
    pending_next  = pending_reg;
    overflow_next = 1'b0;
    if (rise && !start) begin
      if (pending_reg == PEND_MAX) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending_reg + 1'b1;
      end
    end else if (start && !rise) begin
      pending_next = pending_reg - 1'b1;
    end
  end

  // in_prev resets high so a level already present at reset release is not an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      pending_reg  <= '0;
      in_prev_reg  <= 1'b1;
      out_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      pending_reg  <= pending_next;
      in_prev_reg  <= bus.in;
      out_reg      <= (state_next == ON);
      busy_reg     <= (state_next != IDLE);
      overflow_reg <= overflow_next;
    end
  end

  assign bus.out      = out_reg;
  assign bus.busy     = busy_reg;
  assign bus.pending  = pending_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_event_stretcher.sv
// Self-checking bench for event_stretcher: directed scenarios plus randomized input,
// compared every cycle against a pulse-timeline reference model.
module tb_event_stretcher;

  localparam int ON   = 8;
  localparam int OFF  = 4;
  localparam int PW   = 3;
  localparam int P    = ON + OFF;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  event_stretcher_if #(.PEND_WIDTH(PW)) bus ();

  event_stretcher #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .PEND_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model: queued-event count plus position inside the current on+off period (-1 = idle).
  int m_pend;
  int m_pos;
  bit m_prev;
  bit m_ovf;

  int st_out_hi, st_busy_hi, st_ovf, st_pulses, st_max_pend, st_busy_run, st_busy_max;
  bit last_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0;
    m_pos  = -1;
    m_prev = 1'b1;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step(input bit v);
    bit rise;
    bit start;
    rise   = v && !m_prev;
    m_prev = v;
    start  = (m_pend > 0) && (m_pos == -1 || m_pos == P - 1);
    m_ovf  = 1'b0;
    if (rise && !start) begin
      if (m_pend == PMAX) m_ovf = 1'b1;
      else m_pend++;
    end else if (start && !rise) begin
      m_pend--;
    end
    if (start) m_pos = 0;
    else if (m_pos == P - 1) m_pos = -1;
    else if (m_pos >= 0) m_pos++;
  endtask

  task automatic clear_stats();
    st_out_hi   = 0;
    st_busy_hi  = 0;
    st_ovf      = 0;
    st_pulses   = 0;
    st_max_pend = 0;
    st_busy_run = 0;
    st_busy_max = 0;
    last_out    = bus.out;
  endtask

  task automatic tick(input bit v);
    bus.in = v;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(v);
    @(negedge clk);
    check("out",      bus.out,      (m_pos >= 0 && m_pos < ON));
    check("busy",     bus.busy,     (m_pos >= 0));
    check("pending",  bus.pending,  m_pend);
    check("overflow", bus.overflow, m_ovf);
    if (bus.out) st_out_hi++;
    if (bus.out && !last_out) st_pulses++;
    last_out = bus.out;
    if (bus.busy) begin
      st_busy_hi++;
      st_busy_run++;
      if (st_busy_run > st_busy_max) st_busy_max = st_busy_run;
    end else begin
      st_busy_run = 0;
    end
    if (bus.overflow) st_ovf++;
    if (int'(bus.pending) > st_max_pend) st_max_pend = int'(bus.pending);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_pend != 0 || m_pos != -1) && n < 300) begin
      tick(1'b0);
      n++;
    end
    check("drain_bound", (n < 300), 1);
    repeat (3) tick(1'b0);
  endtask

  task automatic pulse_train(input int count);
    for (int i = 0; i < count; i++) begin
      tick(1'b1);
      tick(1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int thr;
    rst    = 1'b1;
    bus.in = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_out",      bus.out,      0);
    check("reset_busy",     bus.busy,     0);
    check("reset_pending",  bus.pending,  0);
    check("reset_overflow", bus.overflow, 0);
    rst = 1'b0;
    repeat (3) tick(1'b0);

    // Single isolated event
    clear_stats();
    tick(1'b1);
    check("t1_pend_after_E", bus.pending, 1);
    check("t1_out_low_at_E", bus.out, 0);
    tick(1'b0);
    check("t1_out_high_E1", bus.out, 1);
    check("t1_pend_after_E1", bus.pending, 0);
    drain();
    check("t1_out_cycles",  st_out_hi, ON);
    check("t1_busy_cycles", st_busy_hi, P);
    check("t1_overflows",   st_ovf, 0);
    check("t1_pulses",      st_pulses, 1);

    // Three events spaced two cycles
    clear_stats();
    pulse_train(3);
    drain();
    check("t2_pulses",    st_pulses, 3);
    check("t2_out_cycles", st_out_hi, 3 * ON);
    check("t2_busy_run",  st_busy_max, 3 * P);
    check("t2_max_pend",  st_max_pend, 2);

    // Ten events: queue fills, the tenth is dropped
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      if (i == 9) begin
        check("t3_ovf_on_10th",  bus.overflow, 1);
        check("t3_pend_on_10th", bus.pending, PMAX);
      end else begin
        check("t3_no_ovf_early", bus.overflow, 0);
      end
      tick(1'b0);
    end
    drain();
    check("t3_overflows", st_ovf, 1);
    check("t3_pulses",    st_pulses, 9);
    check("t3_max_pend",  st_max_pend, PMAX);

    // Input held high for 100 cycles
    clear_stats();
    repeat (100) tick(1'b1);
    drain();
    check("t4_pulses",    st_pulses, 1);
    check("t4_out_cycles", st_out_hi, ON);
    check("t4_max_pend",  st_max_pend, 1);

    // Rise landing on the OFF->ON edge with a full queue
    pulse_train(10);
    n = 0;
    while (m_pos != P - 1 && n < 100) begin
      tick(1'b0);
      n++;
    end
    check("t5_align_bound", (n < 100), 1);
    check("t5_pend_before", bus.pending, PMAX);
    tick(1'b1);
    check("t5_pend_coincident", bus.pending, PMAX);
    check("t5_ovf_coincident",  bus.overflow, 0);
    check("t5_out_restart",     bus.out, 1);
    drain();

    // Reset in the third ON cycle with two queued events
    pulse_train(4);
    n = 0;
    while (!(m_pos == 2 && m_pend == 2) && n < 100) begin
      tick(1'b0);
      n++;
    end
    check("t6_align_bound", (n < 100), 1);
    check("t6_out_before_rst", bus.out, 1);
    bus.in = 1'b1;
    rst    = 1'b1;
    #1;
    check("t6_rst_out",     bus.out, 0);
    check("t6_rst_busy",    bus.busy, 0);
    check("t6_rst_pending", bus.pending, 0);
    model_reset();
    repeat (3) tick(1'b1);
    rst = 1'b0;
    clear_stats();
    repeat (30) tick(1'b1);
    check("t6_no_pulse_held", st_pulses, 0);
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    drain();
    check("t6_pulse_after_retoggle", st_pulses, 1);

    // Randomized traffic with varying density and occasional resets
    thr = 30;
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 3))
          0: thr = 10;
          1: thr = 30;
          2: thr = 50;
          default: thr = 90;
        endcase
      end
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        tick(1'($urandom_range(0, 1)));
        tick(1'($urandom_range(0, 1)));
        rst = 1'b0;
      end else begin
        tick(($urandom_range(0, 99) < thr) ? 1'b1 : 1'b0);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
